// File: rtl/f1_delay_ctrl_if.sv
// Handshake and result bundle between the lights FSM and f1_delay_ctrl.
// F1_REACTION_BCD_EN adds the reaction_bcd result field.
interface f1_delay_ctrl_if #(
  parameter int LFSR_W = 16
);
  logic              start_delay;
  logic [LFSR_W-1:0] lfsr_val;
  logic              button;
  logic              tick_ms;
  logic              time_out;
  logic              busy;
  logic [13:0]       reaction_ms;
  logic              reaction_valid;
  logic              jump_start;
`ifdef F1_REACTION_BCD_EN
  logic [15:0]       reaction_bcd;

  modport master (
    output start_delay, lfsr_val, button,
    input  tick_ms, time_out, busy, reaction_ms, reaction_valid, jump_start, reaction_bcd
  );
  modport slave (
    input  start_delay, lfsr_val, button,
    output tick_ms, time_out, busy, reaction_ms, reaction_valid, jump_start, reaction_bcd
  );
`else
  modport master (
    output start_delay, lfsr_val, button,
    input  tick_ms, time_out, busy, reaction_ms, reaction_valid, jump_start
  );
  modport slave (
    input  start_delay, lfsr_val, button,
    output tick_ms, time_out, busy, reaction_ms, reaction_valid, jump_start
  );
`endif
endinterface

// File: rtl/f1_delay_ctrl.sv
// Random hold after the fifth light pair, lights-out pulse and reaction timing.
// F1_REACTION_BCD_EN adds a sequential binary-to-BCD converter on the reaction result.
module f1_delay_ctrl #(
  parameter int CYCLES_PER_MS = 50000,
  parameter int LFSR_W        = 16,
  parameter int RAND_W        = 12,
  parameter int MIN_DELAY_MS  = 250,
  parameter int REACT_MAX_MS  = 9999
) (
  input logic            i_sysclk,
  input logic            i_rst,
  f1_delay_ctrl_if.slave io_bus
);
  localparam int            PW         = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam int            DW         = RAND_W + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_MS - 1);
  localparam logic [13:0]   REACT_MAX  = 14'(REACT_MAX_MS);

  // IDLE: idle | WAIT: hold running | REACT: timing driver | DONE: result held | JUMP: jump start
  typedef enum logic [2:0] {IDLE, WAIT, REACT, DONE, JUMP} state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [DW-1:0] r_hold;
  logic [13:0]   r_react;
  logic [13:0]   r_reaction_ms;
  logic          r_btn_q;
  logic          r_time_out;
  logic          r_busy;
  logic          r_jump;
  logic          r_valid;

  logic          w_tick;
  logic          w_press;
  logic          w_sat;
  logic          w_capture;
  logic [DW-1:0] w_dly;
  logic [13:0]   w_react_inc;
  logic [13:0]   w_cap_val;
  logic          w_unused;

  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_press     = io_bus.button & ~r_btn_q;
  assign w_dly       = DW'(MIN_DELAY_MS) + DW'(io_bus.lfsr_val[RAND_W-1:0]);
  assign w_react_inc = r_react + 14'd1;
  assign w_sat       = w_tick & (w_react_inc >= REACT_MAX);
  assign w_capture   = (r_state == REACT) & (w_press | w_sat);
  // A press on a tick cycle wins and keeps the pre-increment count.
  assign w_cap_val   = w_press ? r_react : REACT_MAX;
  assign w_unused    = ^io_bus.lfsr_val;

  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_btn_q <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_btn_q <= io_bus.button;
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_react    <= '0;
      r_time_out <= 1'b0;
      r_busy     <= 1'b0;
      r_jump     <= 1'b0;
`ifndef F1_REACTION_BCD_EN
      r_reaction_ms <= '0;
      r_valid       <= 1'b0;
`endif
    end else begin
      r_time_out <= 1'b0;
`ifndef F1_REACTION_BCD_EN
      r_valid    <= 1'b0;
`endif
      case (r_state)
        IDLE, DONE, JUMP: begin
          if (io_bus.start_delay) begin
            r_state <= WAIT;
            r_hold  <= w_dly;
            r_react <= '0;
            r_jump  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (w_press) begin
            r_state <= JUMP;
            r_jump  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            if (r_hold <= DW'(1)) begin
              r_state    <= REACT;
              r_time_out <= 1'b1;
            end else begin
              r_hold <= r_hold - 1'b1;
            end
          end
        end
        REACT: begin
          if (w_capture) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
`ifndef F1_REACTION_BCD_EN
            r_reaction_ms <= w_cap_val;
            r_valid       <= 1'b1;
`endif
          end else if (w_tick) begin
            r_react <= w_react_inc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef F1_REACTION_BCD_EN
  logic [13:0] r_bin;
  logic [13:0] r_conv_src;
  logic [15:0] r_acc;
  logic [15:0] r_bcd;
  logic [3:0]  r_iter;
  logic [15:0] w_acc_adj;
  logic [15:0] w_acc_next;

  always_comb begin
    w_acc_adj = r_acc;
    for (int d = 0; d < 4; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end
  end

  assign w_acc_next = {w_acc_adj[14:0], r_bin[13]};

  // Shift-add-3, one bit per cycle; results and valid publish together on the last bit.
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_bin         <= '0;
      r_conv_src    <= '0;
      r_acc         <= '0;
      r_bcd         <= '0;
      r_iter        <= '0;
      r_reaction_ms <= '0;
      r_valid       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_capture) begin
        r_bin      <= w_cap_val;
        r_conv_src <= w_cap_val;
        r_acc      <= '0;
        r_iter     <= 4'd14;
      end else if (r_iter != 4'd0) begin
        r_acc  <= w_acc_next;
        r_bin  <= r_bin << 1;
        r_iter <= r_iter - 1'b1;
        if (r_iter == 4'd1) begin
          r_bcd         <= w_acc_next;
          r_reaction_ms <= r_conv_src;
          r_valid       <= 1'b1;
        end
      end
    end
  end

  assign io_bus.reaction_bcd = r_bcd;
`endif

  assign io_bus.tick_ms        = w_tick;
  assign io_bus.time_out       = r_time_out;
  assign io_bus.busy           = r_busy;
  assign io_bus.reaction_ms    = r_reaction_ms;
  assign io_bus.reaction_valid = r_valid;
  assign io_bus.jump_start     = r_jump;
endmodule
